// File: rtl/ws2812b_frame_scheduler_if.sv
// Host/driver-facing signal bundle of the WS2812B frame scheduler.
// slave = the scheduler itself, master = the host plus serial-driver side.
interface ws2812b_frame_scheduler_if #(
   parameter int ADDR_W = 10
);
   logic              EN;
   logic              HOST_SWAP_REQ;
   logic              HOST_SWAP_ACK;
   logic              FRONT_BANK;
   logic              DRV_START;
   logic              DRV_BUSY;
   logic [ADDR_W-1:0] DRV_ADDR;
   logic [ADDR_W:0]   RAM_RD_ADDR;
   logic [15:0]       FRAME_COUNT;
   logic              OVERRUN;
   logic              DRV_FAULT;
   logic              CLR_FLAGS;

   modport slave (
      input  EN, HOST_SWAP_REQ, DRV_BUSY, DRV_ADDR, CLR_FLAGS,
      output HOST_SWAP_ACK, FRONT_BANK, DRV_START, RAM_RD_ADDR,
             FRAME_COUNT, OVERRUN, DRV_FAULT
   );

   modport master (
      output EN, HOST_SWAP_REQ, DRV_BUSY, DRV_ADDR, CLR_FLAGS,
      input  HOST_SWAP_ACK, FRONT_BANK, DRV_START, RAM_RD_ADDR,
             FRAME_COUNT, OVERRUN, DRV_FAULT
   );
endinterface

// File: rtl/ws2812b_frame_scheduler.sv
// Frame pacing for the WS2812B driver: one driver frame per tick, with
// double-buffered pixel RAM whose bank swaps only between frames.
module ws2812b_frame_scheduler #(
   parameter int FRAME_TICKS = 333333,
   parameter int ACK_TIMEOUT = 16,
   parameter int ADDR_W      = 10
) (
   input logic                      CLK,
   input logic                      RESET,
   ws2812b_frame_scheduler_if.slave bus
);
   localparam int CNT_W = $clog2(FRAME_TICKS);
   localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(FRAME_TICKS - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_ACK, STREAM} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [15:0]      fcnt_q, fcnt_d;
   logic             front_q, front_d;
   logic             ack_q, ack_d;
   logic             start_q, start_d;
   logic             ovr_q, ovr_d;
   logic             flt_q, flt_d;
   logic             tick;

   assign tick = bus.EN && (tick_cnt_q == TICK_LAST);

   // Free-running while enabled, even mid-frame, so the frame rate never drifts.
   always_comb begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
      if (!bus.EN || tick) tick_cnt_d = '0;
   end

   always_comb begin
      state_d = state_q;
      to_d    = to_q;
      fcnt_d  = fcnt_q;
      front_d = front_q;
      ack_d   = 1'b0;
      start_d = 1'b0;
      ovr_d   = ovr_q;
      flt_d   = flt_q;
      if (bus.CLR_FLAGS) begin
         ovr_d = 1'b0;
         flt_d = 1'b0;
      end
      // Ticks landing mid-frame are dropped, not queued.
      if (tick && state_q != IDLE) ovr_d = 1'b1;
      case (state_q)
         IDLE: if (tick) begin
            state_d = START;
            start_d = 1'b1;
            if (bus.HOST_SWAP_REQ) begin
               front_d = ~front_q;
               ack_d   = 1'b1;
            end
         end
         START: begin
            state_d = WAIT_ACK;
            to_d    = TO_LAST;
         end
         WAIT_ACK: begin
            if (bus.DRV_BUSY) begin
               state_d = STREAM;
            end else if (to_q == '0) begin
               flt_d   = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q - TO_W'(1);
            end
         end
         STREAM: if (!bus.DRV_BUSY) begin
            fcnt_d  = fcnt_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         to_q       <= '0;
         fcnt_q     <= '0;
         front_q    <= 1'b0;
         ack_q      <= 1'b0;
         start_q    <= 1'b0;
         ovr_q      <= 1'b0;
         flt_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         to_q       <= to_d;
         fcnt_q     <= fcnt_d;
         front_q    <= front_d;
         ack_q      <= ack_d;
         start_q    <= start_d;
         ovr_q      <= ovr_d;
         flt_q      <= flt_d;
      end
   end

   assign bus.HOST_SWAP_ACK = ack_q;
   assign bus.FRONT_BANK    = front_q;
   assign bus.DRV_START     = start_q;
   assign bus.RAM_RD_ADDR   = {front_q, bus.DRV_ADDR};
   assign bus.FRAME_COUNT   = fcnt_q;
   assign bus.OVERRUN       = ovr_q;
   assign bus.DRV_FAULT     = flt_q;
endmodule
